uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received character together with its parity and framing error flags on the receiver's `data_ready` strobe. It holds the characters in a first-word-fall-through FIFO for a slower consumer (CPU bus or loopback logic) and reports fill level, a level-threshold flag and a sticky overrun flag when characters arrive into a full buffer.

---
 rtl/uart_rx_fifo.sv | 83 ++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side FWFT character FIFO with error flags, level flag and sticky overrun
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_BITS-1:0]       rx_data,
  input  logic                       data_ready,
  input  logic                       parity_err,
  input  logic                       frame_err,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       level_flag,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign level_flag = (count >= CW'(THRESHOLD));

  // A full FIFO still accepts a character when the consumer frees a slot in the same cycle.
  assign push = data_ready && (!full || rd_en);
  assign pop  = rd_en && !empty;
  assign drop = data_ready && full && !rd_en;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {frame_err, parity_err, rx_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign head          = mem[rd_ptr];
  assign rd_data       = empty ? '0   : head[DATA_BITS-1:0];
  assign rd_parity_err = empty ? 1'b0 : head[DATA_BITS];
  assign rd_frame_err  = empty ? 1'b0 : head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       level_flag;
  logic       overrun;
  logic       overrun_clr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESHOLD(8)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .rd_en(rd_en),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .empty(empty), .full(full), .count(count), .level_flag(level_flag),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    rx_data    = d;
    parity_err = pe;
    frame_err  = fe;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  logic [9:0] model_q[$];
  logic [9:0] e;

  initial begin
    reset_n = 1'b0; rx_data = '0; data_ready = 1'b0; parity_err = 1'b0;
    frame_err = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'h00);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Single character with a parity error.
    push(8'hA5, 1'b1, 1'b0);
    chk("single_data", 32'(rd_data), 32'hA5);
    chk("single_pe", 32'(rd_parity_err), 32'd1);
    chk("single_fe", 32'(rd_frame_err), 32'd0);
    chk("single_count", 32'(count), 32'd1);
    pop();
    chk("single_pop_empty", 32'(empty), 32'd1);
    chk("single_pop_data", 32'(rd_data), 32'h00);

    // rd_en while empty has no effect.
    pop();
    chk("empty_pop_count", 32'(count), 32'd0);

    // Fill to full, then overrun.
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_level", 32'(level_flag), 32'((i + 1) >= 8));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    push(8'h55, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(rd_data), 32'h00);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i));
      pop();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_no_55", 32'(rd_data), 32'h00);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
    chk("full2", 32'(full), 32'd1);
    rx_data = 8'h77; data_ready = 1'b1; rd_en = 1'b1;
    tick();
    data_ready = 1'b0; rd_en = 1'b0;
    chk("fullrw_count", 32'(count), 32'd16);
    chk("fullrw_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk("fullrw_order", 32'(rd_data), 32'(8'h10 + i));
      pop();
    end
    chk("fullrw_last", 32'(rd_data), 32'h77);
    pop();
    chk("fullrw_empty", 32'(empty), 32'd1);

    // Empty + push + pop: only the push happens.
    rx_data = 8'h3C; data_ready = 1'b1; rd_en = 1'b1;
    tick();
    data_ready = 1'b0; rd_en = 1'b0;
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_data", 32'(rd_data), 32'h3C);
    pop();

    // Pointer wrap at a steady fill level of 3.
    for (int k = 0; k < 3; k++) begin
      model_q.push_back({k[1], k[0], 8'(8'h80 + k)});
      push(8'(8'h80 + k), k[0], k[1]);
    end
    for (int k = 3; k < 43; k++) begin
      e = model_q.pop_front();
      chk("wrap_data", 32'(rd_data), 32'(e[7:0]));
      chk("wrap_pe", 32'(rd_parity_err), 32'(e[8]));
      chk("wrap_fe", 32'(rd_frame_err), 32'(e[9]));
      model_q.push_back({k[1], k[0], 8'(8'h80 + k)});
      rx_data = 8'(8'h80 + k); parity_err = k[0]; frame_err = k[1];
      data_ready = 1'b1; rd_en = 1'b1;
      tick();
      data_ready = 1'b0; rd_en = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
      chk("wrap_count", 32'(count), 32'd3);
    end
    while (model_q.size() > 0) begin
      e = model_q.pop_front();
      chk("wrap_tail", 32'(rd_data), 32'(e[7:0]));
      pop();
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Overrun clear collides with a new overrun: set wins.
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i), 1'b0, 1'b0);
    push(8'hEE, 1'b0, 1'b0);
    chk("ovr2_set", 32'(overrun), 32'd1);
    rx_data = 8'hEF; data_ready = 1'b1; overrun_clr = 1'b1;
    tick();
    data_ready = 1'b0; overrun_clr = 1'b0;
    chk("ovr_clr_collide", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr_alone", 32'(overrun), 32'd0);
    push(8'hF0, 1'b1, 1'b1);
    chk("ovr3_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 11; i++) pop();
    chk("pre_reset_count", 32'(count), 32'd5);
    chk("pre_reset_data", 32'(rd_data), 32'hCB);

    // Asynchronous reset mid-cycle with a concurrent data_ready.
    #2;
    rx_data = 8'h99; data_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_level", 32'(level_flag), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'h00);
    chk("arst_flags", 32'({rd_parity_err, rd_frame_err}), 32'd0);
    tick();
    data_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_reset_empty", 32'(empty), 32'd1);
    chk("post_reset_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
